// File: rtl/hdshk_data_rx.sv
// Purpose : destination-domain receiver for a four-phase req/ack bundled-data
//           handshake. It synchronizes req_a, captures data_a and presents the
//           word to a local consumer over a valid/ready interface.
// Latency : req_a rise to dout_valid takes SYNC_STAGES+1 clk_b edges. ack_b
//           rises on the accept edge. req_a fall to ack_b low takes
//           SYNC_STAGES+1 edges.
// Backpressure: the word is held in VALID while dout_ready is low. ack_b, and
//           therefore the sender, waits until the consumer accepts the word.
//
// Ports:
//   clk_b       destination clock (the only clock)
//   rst_n       asynchronous active-low reset
//   req_a       request level from the sender domain (asynchronous)
//   data_a      bundled data, stable while req_a is high until ack_b is seen
//   ack_b       registered acknowledge level back to the sender
//   dout        captured data word (registered)
//   dout_valid  dout holds an unconsumed word
//   dout_ready  consumer accepts dout when dout_valid && dout_ready
//   busy        handshake in progress (state != IDLE)
//   proto_err   sticky: req_a dropped before ack_b rose
//
// SYNC_STAGES must be in the range 2..4.
module hdshk_data_rx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_b,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  output logic             ack_b,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             proto_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VALID = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   req_s;
  logic                   capture;
  logic                   err_set;

  // The synchronizer is a plain shift chain with no logic between stages.
  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], req_a};
    end
  end

  assign req_s = sync[SYNC_STAGES-1];

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (req_s) begin
          // data_a has been stable since before req_a rose, so sampling it
          // here without synchronization is safe.
          capture   = 1'b1;
          state_nxt = VALID;
        end
      end
      VALID: begin
        // If the sender drops req early, flag it but still deliver the word.
        if (!req_s) begin
          err_set = 1'b1;
        end
        if (dout_ready) begin
          state_nxt = ACK;
        end
      end
      ACK: begin
        if (!req_s) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Registered outputs are loaded from the next state, so they change on the
  // same edge as the state transition.
  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      ack_b      <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      if (capture) begin
        dout <= data_a;
      end
      dout_valid <= (state_nxt == VALID);
      ack_b      <= (state_nxt == ACK);
      if (err_set) begin
        proto_err <= 1'b1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
